// File: rtl/seq_cs_adder.sv
// Multi-cycle carry-select adder: one BLK-bit chunk per cycle behind a start/done handshake.
// Optional define CSA_OVF_EN adds a registered signed-overflow output (ovf).
module seq_cs_adder #(
  parameter int WIDTH = 8,
  parameter int BLK   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef CSA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  // state | meaning
  // IDLE  | waiting for start; sum/cout hold the last completed result
  // CALC  | adding chunk idx, one chunk per clock, LSB chunk first

  localparam int NBLK = WIDTH / BLK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b, work;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic             accept, last;
  logic [31:0]      sh;
  logic [WIDTH-1:0] a_sh, b_sh, chunk_mask, work_nxt;
  logic [BLK-1:0]   a_k, b_k;
  logic [BLK:0]     s0, s1, sel;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (idx == LAST_IDX) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both candidate chunk sums are formed; the registered chunk carry picks one.
  always_comb begin
    sh         = 32'(idx) * 32'(BLK);
    a_sh       = op_a >> sh;
    b_sh       = op_b >> sh;
    a_k        = a_sh[BLK-1:0];
    b_k        = b_sh[BLK-1:0];
    s0         = {1'b0, a_k} + {1'b0, b_k};
    s1         = s0 + (BLK+1)'(1);
    sel        = carry ? s1 : s0;
    chunk_mask = WIDTH'({BLK{1'b1}}) << sh;
    work_nxt   = (work & ~chunk_mask) | (WIDTH'(sel[BLK-1:0]) << sh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef CSA_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a  <= a;
        op_b  <= b;
        carry <= cin;
        idx   <= '0;
        work  <= '0;
        busy  <= 1'b1;
      end else if (state == CALC) begin
        work  <= work_nxt;
        carry <= sel[BLK];
        if (last) begin
          sum  <= work_nxt;
          cout <= sel[BLK];
          done <= 1'b1;
          busy <= 1'b0;
`ifdef CSA_OVF_EN
          ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (work_nxt[WIDTH-1] != op_a[WIDTH-1]);
`endif
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_cs_adder.sv
// Directed self-checking bench for seq_cs_adder (8/2 instance plus a 2/1 bit-serial instance).
module tb_seq_cs_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef CSA_OVF_EN
  logic       ovf;
`endif

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
`ifdef CSA_OVF_EN
  logic       ovf2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_cs_adder #(.WIDTH(8), .BLK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef CSA_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  seq_cs_adder #(.WIDTH(2), .BLK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2),
`ifdef CSA_OVF_EN
    .ovf(ovf2),
`endif
    .cout(cout2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // drive one start pulse; returns #1 after the accepting edge
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // cycles until done (bounded); -1 on timeout
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      cyc();
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
    cyc(); cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL reset_sum got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout); end
    start = 1'b0; start2 = 1'b0;
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_carry_chain();
    int n;
    start_op(8'hFF, 8'h01, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL chain_busy got %b want 1", busy); end
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL chain_latency got %0d want 4", n); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL chain_sum got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL chain_cout got %b want 1", cout); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL chain_busy_end got %b want 0", busy); end
    cyc();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL chain_done_pulse got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00 || cout !== 1'b1) begin
      n_bad++; $display("FAIL chain_hold got %h/%b want 00/1", sum, cout);
    end
  endtask

  task automatic test_mixed();
    int n;
    int holds_bad;
    holds_bad = 0;
    start_op(8'hA5, 8'h3C, 1'b1);
    n = 0;
    while (!done && n < 20) begin
      if (sum !== 8'h00 || cout !== 1'b1) holds_bad++;
      cyc();
      n++;
    end
    n_cmp++; if (holds_bad !== 0) begin n_bad++; $display("FAIL mixed_hold_prev got %0d bad cycles want 0", holds_bad); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL mixed_latency got %0d want 4", n); end
    n_cmp++; if (sum !== 8'hE2) begin n_bad++; $display("FAIL mixed_sum got %h want e2", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL mixed_cout got %b want 0", cout); end
    cyc();
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [7:0] got_sum;
    logic got_cout;
    dones = 0; got_sum = 8'hxx; got_cout = 1'bx;
    start_op(8'h10, 8'h20, 1'b0);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin dones++; got_sum = sum; got_cout = cout; end
      cyc();
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL busy_start_dones got %0d want 1", dones); end
    n_cmp++; if (got_sum !== 8'h30) begin n_bad++; $display("FAIL busy_start_sum got %h want 30", got_sum); end
    n_cmp++; if (got_cout !== 1'b0) begin n_bad++; $display("FAIL busy_start_cout got %b want 0", got_cout); end
  endtask

  task automatic test_abort();
    int dones;
    int n;
    dones = 0;
    start_op(8'h55, 8'hAA, 1'b1);
    cyc();
    rst_n = 1'b0;
    cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (sum !== 8'h00) begin n_bad++; $display("FAIL abort_sum got %h want 00", sum); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      cyc();
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", dones); end
    start_op(8'h01, 8'h01, 1'b0);
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL abort_next_latency got %0d want 4", n); end
    n_cmp++; if (sum !== 8'h02 || cout !== 1'b0) begin
      n_bad++; $display("FAIL abort_next_sum got %h/%b want 02/0", sum, cout);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(8'h0F, 8'h01, 1'b0);
    wait_done(n);
    n_cmp++; if (sum !== 8'h10) begin n_bad++; $display("FAIL b2b_first_sum got %h want 10", sum); end
    start_op(8'h20, 8'h22, 1'b1);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept got done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL b2b_latency got %0d want 4", n); end
    n_cmp++; if (sum !== 8'h43 || cout !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second_sum got %h/%b want 43/0", sum, cout);
    end
    cyc();
  endtask

  task automatic test_bit_serial();
    int n;
    a2 = 2'b11; b2 = 2'b10; cin2 = 1'b1; start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 20) begin
      cyc();
      n++;
    end
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL serial_latency got %0d want 2", n); end
    n_cmp++; if (sum2 !== 2'b10) begin n_bad++; $display("FAIL serial_sum got %b want 10", sum2); end
    n_cmp++; if (cout2 !== 1'b1) begin n_bad++; $display("FAIL serial_cout got %b want 1", cout2); end
    cyc();
  endtask

`ifdef CSA_OVF_EN
  task automatic test_ovf();
    int n;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(n);
    n_cmp++; if (sum !== 8'h80 || cout !== 1'b0) begin
      n_bad++; $display("FAIL ovf_sum got %h/%b want 80/0", sum, cout);
    end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_pos got %b want 1", ovf); end
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(n);
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_none got %b want 0", ovf); end
    cyc();
  endtask
`endif

  initial begin
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_carry_chain();
    test_mixed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_bit_serial();
`ifdef CSA_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
